uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Serialises one parallel byte per handshake into an asynchronous UART frame (start, data LSB-first,
//  optional parity, stop). Sits directly downstream of the baud divider: consumes its square-wave
//  baud output (clkOut) as a data signal in the clkSys domain, not as a clock. One rising edge of
//  that signal marks one bit period. Drives the pad-side TX line.
// PARAMETERS
//  DATA_BITS  8  data bits per frame, legal 5..9
//  PARITY     0  0 = none, 1 = odd, 2 = even
//  STOP_BITS  1  stop bits per frame, legal 1..2
// PORTS
//  clkSys     in   1          system clock; all flops on posedge
//  rst        in   1          synchronous, active-high reset
//  baudClk    in   1          baud square wave from divider clkOut, synchronous to clkSys
//  dataIn     in   DATA_BITS  byte to send, sampled on accept
//  validIn    in   1          upstream has dataIn valid
//  readyOut   out  1          engine can accept; accept = validIn & readyOut
//  txOut      out  1          serial line, idle high
//  busy       out  1          frame in progress (any state other than IDLE)
//  txDone     out  1          one-cycle pulse when final stop bit period completes
// BEHAVIOUR
//  - Reset (rst=1 at posedge): txOut=1, readyOut=1, busy=0, txDone=0, state IDLE, counters 0.
//    Applies mid-frame too: frame abandoned, line high next cycle, no partial resumption.
//  - tick = baudClk & ~baudClk_q (registered previous value). No synchroniser: same clock domain.
//    One tick per baud period; every bit is held for exactly one tick-to-tick interval.
//  - States: IDLE -> ALIGN -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: readyOut=1, txOut=1; ticks ignored. On accept: latch dataIn into shift reg, compute
//      parity bit (even: ^data, odd: ~^data), go ALIGN; readyOut=0 from the next cycle.
//    ALIGN: txOut=1; on tick -> txOut<=0, go START. A tick in the accept cycle itself is ignored,
//      so the start edge lands on the first tick strictly after accept (latency 1..P+1 clkSys).
//    START: on tick -> txOut<=shift[0], bitIdx<=0, go DATA.
//    DATA: on tick -> if bitIdx==DATA_BITS-1: go PARITY (txOut<=parity) if PARITY!=0, else go
//      STOP (txOut<=1, stopCnt<=0); otherwise shift right, bitIdx++, txOut<=next bit.
//    PARITY: on tick -> txOut<=1, stopCnt<=0, go STOP.
//    STOP: txOut=1; on tick -> if stopCnt==STOP_BITS-1: go IDLE, txDone=1 for that one cycle,
//      readyOut=1 the next cycle; else stopCnt++.
//  - Back-to-back: validIn may stay high; the next accept occurs the cycle after re-entering IDLE.
//    Its start bit begins at the following tick, so no extra idle bit is inserted beyond alignment.
//  - validIn/dataIn changing while busy have no effect. dataIn is never re-sampled mid-frame.
//  - bitIdx width $clog2(DATA_BITS). stopCnt is 1 bit. All outputs registered (no comb path to txOut).
//  - Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods after alignment.
// STRUCTURE
//  - uart_pkg: state encoding localparams (IDLE, ALIGN, START, DATA, PARITY, STOP); parity
//    constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2; shared with the future uart_rx.
//  - Sub-module baud_edge_detect (clkSys, rst, baudClk -> tick); the receiver reuses it.
//  - Remainder is a single FSM plus shift register in uart_tx_engine.
// TESTING  (bench drives baudClk from the divider with freq_Sys=16, baudRate=1 -> tick every 16 clkSys)
//  1. Hold rst 3 cycles, release -> txOut=1, readyOut=1, busy=0, txDone=0; no activity across 100 ticks.
//  2. PARITY=0, STOP_BITS=1, send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; single txDone pulse.
//  3. PARITY=2 with 8'h07 -> parity bit 1; PARITY=1 with 8'h07 -> parity bit 0; STOP_BITS=2 -> stop held 32 cycles.
//  4. validIn held high with 8'h55 then 8'hFF -> second accept on the cycle after txDone; 2nd start bit at next tick.
//  5. Accept on the same cycle as a tick -> txOut stays 1 until the following tick, 16 cycles later.
//  6. Assert rst during DATA bit 3 of 8'hA5 -> txOut=1 and readyOut=1 next cycle; no txDone; next frame is clean.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (transmitter FSM states, parity modes)
//   Used by uart_tx_engine and intended for reuse by the future uart_rx.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } txState_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
endpackage

// File: rtl/baud_edge_detect.sv
// baud_edge_detect: turns the divider's baud square wave into a one-cycle tick
//   clkSys  in  system clock
//   rst     in  synchronous active-high reset
//   baudClk in  baud square wave, already synchronous to clkSys
//   tick    out high for one clkSys cycle on each rising edge of baudClk
module baud_edge_detect
    import uart_pkg::*;
(
    input  logic clkSys,
    input  logic rst,
    input  logic baudClk,
    output logic tick
);
    logic baudQ;

    always_ff @(posedge clkSys) begin
        if (rst) baudQ <= 1'b0;
        else     baudQ <= baudClk;
    end

    assign tick = baudClk & ~baudQ;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises one byte per valid/ready handshake into a UART frame
//   clkSys   in  system clock
//   rst      in  synchronous active-high reset
//   baudClk  in  baud square wave (data signal, one rising edge per bit period)
//   dataIn   in  word to send, sampled on accept
//   validIn  in  upstream has dataIn valid
//   readyOut out engine can accept (accept = validIn & readyOut)
//   txOut    out serial line, idle high
//   busy     out frame in progress
//   txDone   out one-cycle pulse when the final stop bit period ends
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clkSys,
    input  logic                 rst,
    input  logic                 baudClk,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 validIn,
    output logic                 readyOut,
    output logic                 txOut,
    output logic                 busy,
    output logic                 txDone
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    txState_t state, stateNxt;
    logic [DATA_BITS-1:0] shiftReg, shiftNxt;
    logic [IDX_W-1:0] bitIdx, bitIdxNxt;
    logic stopCnt, stopCntNxt;
    logic parBit, parBitNxt;
    logic txNxt, doneNxt, tick, accept;

    baud_edge_detect uEdge (
        .clkSys  (clkSys),
        .rst     (rst),
        .baudClk (baudClk),
        .tick    (tick)
    );

    // readyOut is only high while idle, so this is also the IDLE-state accept
    assign accept = validIn & readyOut;

    always_comb begin
        stateNxt   = state;
        shiftNxt   = shiftReg;
        bitIdxNxt  = bitIdx;
        stopCntNxt = stopCnt;
        parBitNxt  = parBit;
        txNxt      = txOut;
        doneNxt    = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                shiftNxt  = dataIn;
                parBitNxt = (PARITY == PAR_ODD) ? ~^dataIn : ^dataIn;
                stateNxt  = ST_ALIGN;
            end
            // waits for the first tick after accept so the start bit is a full period
            ST_ALIGN: if (tick) begin
                txNxt    = 1'b0;
                stateNxt = ST_START;
            end
            ST_START: if (tick) begin
                txNxt     = shiftReg[0];
                bitIdxNxt = '0;
                stateNxt  = ST_DATA;
            end
            ST_DATA: if (tick) begin
                if (bitIdx == LAST_IDX) begin
                    if (PARITY != PAR_NONE) begin
                        txNxt    = parBit;
                        stateNxt = ST_PARITY;
                    end else begin
                        txNxt      = 1'b1;
                        stopCntNxt = 1'b0;
                        stateNxt   = ST_STOP;
                    end
                end else begin
                    shiftNxt  = shiftReg >> 1;
                    bitIdxNxt = bitIdx + 1'b1;
                    txNxt     = shiftReg[1];
                end
            end
            ST_PARITY: if (tick) begin
                txNxt      = 1'b1;
                stopCntNxt = 1'b0;
                stateNxt   = ST_STOP;
            end
            ST_STOP: if (tick) begin
                if (stopCnt == STOP_LAST) begin
                    stateNxt = ST_IDLE;
                    doneNxt  = 1'b1;
                end else begin
                    stopCntNxt = 1'b1;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkSys) begin
        if (rst) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            bitIdx   <= '0;
            stopCnt  <= 1'b0;
            parBit   <= 1'b0;
            txOut    <= 1'b1;
            readyOut <= 1'b1;
            busy     <= 1'b0;
            txDone   <= 1'b0;
        end else begin
            state    <= stateNxt;
            shiftReg <= shiftNxt;
            bitIdx   <= bitIdxNxt;
            stopCnt  <= stopCntNxt;
            parBit   <= parBitNxt;
            txOut    <= txNxt;
            // ready lags IDLE entry by one cycle, so it rises the cycle after txDone
            readyOut <= (state == ST_IDLE) & ~accept;
            busy     <= stateNxt != ST_IDLE;
            txDone   <= doneNxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: bench for three uart_tx_engine configurations sharing one stimulus
//   dut0: no parity, 1 stop; dut1: even parity, 1 stop; dut2: odd parity, 2 stops
module tb_uart_tx_engine;
    logic clkSys = 1'b0;
    logic rst = 1'b1;
    logic validIn = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [3:0] baudCnt = 4'd0;
    logic baudClk;
    logic [2:0] txOut, readyOut, busy, txDone;
    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;
    int doneCnt [3] = '{0, 0, 0};

    always #5 clkSys = ~clkSys;

    // divider model: freq 16, baud 1 -> one rising edge every 16 clkSys
    always @(posedge clkSys) baudCnt <= baudCnt + 4'd1;
    assign baudClk = baudCnt[3];
    wire tickNow = (baudCnt == 4'd8);

    uart_tx_engine #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clkSys(clkSys), .rst(rst), .baudClk(baudClk), .dataIn(dataIn), .validIn(validIn),
        .readyOut(readyOut[0]), .txOut(txOut[0]), .busy(busy[0]), .txDone(txDone[0]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clkSys(clkSys), .rst(rst), .baudClk(baudClk), .dataIn(dataIn), .validIn(validIn),
        .readyOut(readyOut[1]), .txOut(txOut[1]), .busy(busy[1]), .txDone(txDone[1]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
        .clkSys(clkSys), .rst(rst), .baudClk(baudClk), .dataIn(dataIn), .validIn(validIn),
        .readyOut(readyOut[2]), .txOut(txOut[2]), .busy(busy[2]), .txDone(txDone[2]));

    task automatic check(input string name, input int d, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic int frameLen(input int d);
        return 10 + (d != 0 ? 1 : 0) + (d == 2 ? 1 : 0);
    endfunction

    // line values per bit period: start, data LSB first, parity, stop(s)
    function automatic logic [11:0] mkFrame(input int d, input logic [7:0] b);
        logic [11:0] f;
        int ones = $countones(b);
        f = {3'b111, b, 1'b0};
        if (d == 1) f[9] = (ones % 2 == 1);
        if (d == 2) f[9] = (ones % 2 == 0);
        return f;
    endfunction

    // reference model: a frame is a list of bit values; each tick after the accept
    // cycle puts the next one on the line, and the tick after the last ends the frame
    bit mActive [3];
    logic [11:0] mFrame [3];
    int mPos [3];
    logic [2:0] expTx, expRdy, expBsy, expDn;

    always @(posedge clkSys) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mActive[d] <= 1'b0;
                mPos[d]    <= 0;
                expTx[d]   <= 1'b1;
                expRdy[d]  <= 1'b1;
                expBsy[d]  <= 1'b0;
                expDn[d]   <= 1'b0;
            end else begin
                expDn[d] <= 1'b0;
                if (!mActive[d]) begin
                    if (validIn && expRdy[d]) begin
                        mFrame[d]  <= mkFrame(d, dataIn);
                        mPos[d]    <= 0;
                        mActive[d] <= 1'b1;
                        expRdy[d]  <= 1'b0;
                        expBsy[d]  <= 1'b1;
                    end else begin
                        expRdy[d] <= 1'b1;
                    end
                end else if (tickNow) begin
                    if (mPos[d] < frameLen(d)) begin
                        expTx[d] <= mFrame[d][mPos[d]];
                        mPos[d]  <= mPos[d] + 1;
                    end else begin
                        mActive[d] <= 1'b0;
                        expDn[d]   <= 1'b1;
                        expBsy[d]  <= 1'b0;
                        expTx[d]   <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clkSys) begin
        for (int d = 0; d < 3; d++) begin
            if (txDone[d]) doneCnt[d] <= doneCnt[d] + 1;
            if (checkEn) begin
                check("model_txOut", d, int'(txOut[d]), int'(expTx[d]));
                check("model_readyOut", d, int'(readyOut[d]), int'(expRdy[d]));
                check("model_busy", d, int'(busy[d]), int'(expBsy[d]));
                check("model_txDone", d, int'(txDone[d]), int'(expDn[d]));
            end
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic [11:0] e [3];
    } vec_t;

    function automatic vec_t mkVec(input logic [7:0] b, input logic pe, input logic po);
        vec_t v;
        v.data = b;
        v.e[0] = {3'b111, b, 1'b0};
        v.e[1] = {2'b11, pe, b, 1'b0};
        v.e[2] = {2'b11, po, b, 1'b0};
        return v;
    endfunction

    task automatic waitAllReady();
        int n = 0;
        while (readyOut != 3'b111 && n < 2000) begin
            @(negedge clkSys);
            n++;
        end
        if (readyOut != 3'b111) check("ready_timeout", 0, 0, 1);
    endtask

    task automatic waitTick();
        int n = 0;
        do begin
            @(negedge clkSys);
            n++;
        end while (!tickNow && n < 40);
        if (!tickNow) check("tick_timeout", 0, 0, 1);
    endtask

    task automatic sendFrame(input logic [7:0] b);
        waitAllReady();
        validIn = 1'b1;
        dataIn  = b;
        @(posedge clkSys);
        #1 validIn = 1'b0;
    endtask

    // sends one table entry and samples every bit period at its midpoint
    task automatic runVec(input vec_t v);
        int snap [3];
        for (int d = 0; d < 3; d++) snap[d] = doneCnt[d];
        sendFrame(v.data);
        for (int k = 0; k < 12; k++) begin
            waitTick();
            repeat (8) @(negedge clkSys);
            for (int d = 0; d < 3; d++)
                if (k < frameLen(d)) check("frame_bit", d, int'(txOut[d]), int'(v.e[d][k]));
        end
        waitAllReady();
        @(negedge clkSys);
        for (int d = 0; d < 3; d++) check("done_pulses", d, doneCnt[d] - snap[d], 1);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = mkVec(8'hA5, 1'b0, 1'b1);
        vecs[1] = mkVec(8'h07, 1'b1, 1'b0);
        vecs[2] = mkVec(8'h00, 1'b0, 1'b1);
        vecs[3] = mkVec(8'hFF, 1'b0, 1'b1);
        vecs[4] = mkVec(8'h80, 1'b1, 1'b0);
        vecs[5] = mkVec(8'h3C, 1'b0, 1'b1);

        @(negedge clkSys);
        checkEn = 1'b1;
        repeat (2) @(negedge clkSys);
        for (int d = 0; d < 3; d++) begin
            check("reset_txOut", d, int'(txOut[d]), 1);
            check("reset_readyOut", d, int'(readyOut[d]), 1);
            check("reset_busy", d, int'(busy[d]), 0);
            check("reset_txDone", d, int'(txDone[d]), 0);
        end
        rst = 1'b0;
        repeat (1600) @(negedge clkSys);
        for (int d = 0; d < 3; d++) begin
            check("idle_txOut", d, int'(txOut[d]), 1);
            check("idle_readyOut", d, int'(readyOut[d]), 1);
            check("idle_no_done", d, doneCnt[d], 0);
        end

        for (int i = 0; i < 6; i++) runVec(vecs[i]);

        // back-to-back with validIn held high: 55 then FF on dut0
        begin
            int n = 0;
            waitAllReady();
            validIn = 1'b1;
            dataIn  = 8'h55;
            @(posedge clkSys);
            #1 dataIn = 8'hFF;
            do begin
                @(negedge clkSys);
                n++;
            end while (!txDone[0] && n < 400);
            check("b2b_done_seen", 0, int'(txDone[0]), 1);
            @(negedge clkSys);
            check("b2b_ready_after_done", 0, int'(readyOut[0]), 1);
            @(negedge clkSys);
            validIn = 1'b0;
            check("b2b_accepted_busy", 0, int'(busy[0]), 1);
            check("b2b_accepted_ready", 0, int'(readyOut[0]), 0);
            repeat (13) @(negedge clkSys);
            check("b2b_line_before_start", 0, int'(txOut[0]), 1);
            @(negedge clkSys);
            check("b2b_start_bit", 0, int'(txOut[0]), 0);
            waitAllReady();
        end

        // accept in the same cycle as a tick: start bit waits for the following tick
        waitAllReady();
        while (!tickNow) @(negedge clkSys);
        validIn = 1'b1;
        dataIn  = 8'h3C;
        @(posedge clkSys);
        #1 validIn = 1'b0;
        repeat (16) @(negedge clkSys);
        for (int d = 0; d < 3; d++) check("tickacc_hold", d, int'(txOut[d]), 1);
        @(negedge clkSys);
        for (int d = 0; d < 3; d++) check("tickacc_start", d, int'(txOut[d]), 0);
        waitAllReady();

        // reset in the middle of data bit 3 of A5
        begin
            int snap [3];
            sendFrame(8'hA5);
            repeat (5) waitTick();
            repeat (4) @(negedge clkSys);
            for (int d = 0; d < 3; d++) begin
                check("rst_pre_bit3", d, int'(txOut[d]), 0);
                snap[d] = doneCnt[d];
            end
            rst = 1'b1;
            @(negedge clkSys);
            rst = 1'b0;
            for (int d = 0; d < 3; d++) begin
                check("rst_mid_txOut", d, int'(txOut[d]), 1);
                check("rst_mid_readyOut", d, int'(readyOut[d]), 1);
                check("rst_mid_busy", d, int'(busy[d]), 0);
                check("rst_mid_txDone", d, int'(txDone[d]), 0);
            end
            repeat (400) @(negedge clkSys);
            for (int d = 0; d < 3; d++) check("rst_no_done", d, doneCnt[d] - snap[d], 0);
            runVec(vecs[0]);
        end

        // random traffic and occasional resets against the model
        repeat (4000) begin
            @(negedge clkSys);
            validIn = ($urandom_range(0, 3) == 0);
            dataIn  = 8'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
        end
        @(negedge clkSys);
        validIn = 1'b0;
        rst     = 1'b0;
        waitAllReady();
        repeat (20) @(negedge clkSys);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
